// File: rtl/mc_control_pkg.sv
// mc_control_pkg: opcodes, 4-bit state encodings, mux select codes and control bundle for the multicycle MIPS control
package mc_control_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQEX  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JEX    = 4'd11;
  localparam logic [1:0] ALU_SRC_B_REG  = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'd2;
  localparam logic [1:0] ALU_SRC_B_IMM4 = 2'd3;
  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
  localparam logic [1:0] ALU_OP_ADD     = 2'd0;
  localparam logic [1:0] ALU_OP_SUB     = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT   = 2'd2;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;
  function automatic logic op_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
  endfunction
endpackage

// File: rtl/mc_control_outdec.sv
// mc_control_outdec: state (+ memory ready in FETCH) to datapath control signals; unused encodings give all-zero
module mc_control_outdec
  import mc_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_ready,
  input  logic       i_bad_op,
  output ctrl_t      o_ctrl
);
  logic w_fetch, w_decode, w_memadr, w_memrd, w_memwb, w_memwr;
  logic w_rtex, w_rtwb, w_beqex, w_addiex, w_addiwb, w_jex;
  assign w_fetch  = i_state == S_FETCH;
  assign w_decode = i_state == S_DECODE;
  assign w_memadr = i_state == S_MEMADR;
  assign w_memrd  = i_state == S_MEMRD;
  assign w_memwb  = i_state == S_MEMWB;
  assign w_memwr  = i_state == S_MEMWR;
  assign w_rtex   = i_state == S_RTEX;
  assign w_rtwb   = i_state == S_RTWB;
  assign w_beqex  = i_state == S_BEQEX;
  assign w_addiex = i_state == S_ADDIEX;
  assign w_addiwb = i_state == S_ADDIWB;
  assign w_jex    = i_state == S_JEX;
  always_comb begin
    o_ctrl.pc_write      = (w_fetch & i_ready) | w_jex;
    o_ctrl.pc_write_cond = w_beqex;
    o_ctrl.i_or_d        = w_memrd | w_memwr;
    o_ctrl.mem_read      = w_fetch | w_memrd;
    o_ctrl.mem_write     = w_memwr;
    o_ctrl.ir_write      = w_fetch & i_ready;
    o_ctrl.mem_to_reg    = w_memwb;
    o_ctrl.reg_dst       = w_rtwb;
    o_ctrl.reg_write     = w_memwb | w_rtwb | w_addiwb;
    o_ctrl.alu_src_a     = w_memadr | w_rtex | w_beqex | w_addiex;
    o_ctrl.alu_src_b     = w_fetch ? ALU_SRC_B_FOUR : w_decode ? ALU_SRC_B_IMM4 :
                           (w_memadr | w_addiex) ? ALU_SRC_B_IMM : ALU_SRC_B_REG;
    o_ctrl.alu_op        = w_rtex ? ALU_OP_FUNCT : w_beqex ? ALU_OP_SUB : ALU_OP_ADD;
    o_ctrl.pc_source     = w_beqex ? PC_SRC_ALUOUT : w_jex ? PC_SRC_JUMP : PC_SRC_ALU;
    o_ctrl.illegal_op    = w_decode & i_bad_op;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main control FSM sequencing fetch/decode/execute/mem/writeback
module mc_control
  import mc_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);
  logic [3:0] r_state, w_next;
  logic       w_rdy, w_unused;
  ctrl_t      w_ctrl;
  assign w_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  // the branch is qualified by zero in the datapath via pc_write_cond
  assign w_unused = zero;
  always_comb begin
    case (r_state)
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR : op == OP_R ? S_RTEX :
                         op == OP_BEQ ? S_BEQEX : op == OP_ADDI ? S_ADDIEX : op == OP_J ? S_JEX : S_FETCH;
      S_MEMADR: w_next = op == OP_LW ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
      S_RTEX:   w_next = S_RTWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  mc_control_outdec u_outdec (
    .i_state  (r_state),
    .i_ready  (w_rdy),
    .i_bad_op (!op_legal(op)),
    .o_ctrl   (w_ctrl)
  );
  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = w_ctrl.illegal_op;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-cycle checks of the control word for every instruction class, reset and no-handshake mode
module tb_mc_control;
  localparam logic [16:0] E_FETCH1 = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH0 = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_RTEX   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_RTWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_JEX    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  logic clk = 0, rst_n = 0, zero = 0, mem_ready = 0;
  logic [5:0] op = 6'h00;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic rst0_n = 0, mem_ready0 = 0;
  logic [5:0] op0 = 6'h2B;
  logic pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0;
  logic mem_to_reg0, reg_dst0, reg_write0, alu_src_a0, illegal_op0;
  logic [1:0] alu_src_b0, alu_op0, pc_source0;
  logic [16:0] w_out, w_out0;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  assign w_out = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
  assign w_out0 = {pc_write0, pc_write_cond0, i_or_d0, mem_read0, mem_write0, ir_write0, mem_to_reg0,
                   reg_dst0, reg_write0, alu_src_a0, alu_src_b0, alu_op0, pc_source0, illegal_op0};
  mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op)
  );
  mc_control #(.MEM_HANDSHAKE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .op(op0), .zero(zero), .mem_ready(mem_ready0),
    .pc_write(pc_write0), .pc_write_cond(pc_write_cond0), .i_or_d(i_or_d0), .mem_read(mem_read0),
    .mem_write(mem_write0), .ir_write(ir_write0), .mem_to_reg(mem_to_reg0), .reg_dst(reg_dst0),
    .reg_write(reg_write0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .pc_source(pc_source0), .illegal_op(illegal_op0)
  );
  task automatic test_reset();
    #3;
    tests++;
    if (w_out !== E_FETCH0) begin failed++; $display("FAIL reset_state: got %b, expected %b", w_out, E_FETCH0); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_r_type();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_RTEX, E_RTWB, E_FETCH0};
    bit r[$] = '{1, 1, 1, 1, 0};
    op = 6'h00;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL r_type cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_lw_wait();
    logic [16:0] e[$] = '{E_FETCH0, E_FETCH0, E_FETCH1, E_DEC, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH0};
    bit r[$] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    int irw = 0;
    op = 6'h23;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      irw += int'(ir_write);
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL lw_wait cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
    tests++;
    if (irw !== 1) begin failed++; $display("FAIL lw_ir_write_pulses: got %0d, expected 1", irw); end
  endtask
  task automatic test_sw_wait();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH0};
    bit r[$] = '{1, 1, 1, 0, 0, 1, 0};
    op = 6'h2B;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL sw_wait cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_beq(input logic z);
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_BEQ, E_FETCH0};
    bit r[$] = '{1, 1, 1, 0};
    op = 6'h04;
    zero = z;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL beq zero=%0b cyc %0d: got %b, expected %b", z, i, w_out, e[i]); end
      @(posedge clk); #1;
    end
    zero = 0;
  endtask
  task automatic test_addi();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_ADDIEX, E_ADDIWB, E_FETCH0};
    bit r[$] = '{1, 1, 1, 1, 0};
    op = 6'h08;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL addi cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_jump();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_JEX, E_FETCH0};
    bit r[$] = '{1, 1, 1, 0};
    op = 6'h02;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL jump cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_illegal();
    logic [16:0] e[$] = '{E_FETCH1, E_DECILL, E_FETCH0, E_FETCH0};
    bit r[$] = '{1, 1, 0, 0};
    op = 6'h3F;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL illegal cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_lw();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_MEMADR, E_MEMRD};
    bit r[$] = '{1, 1, 1, 0};
    op = 6'h23;
    foreach (e[i]) begin
      mem_ready = r[i]; #1;
      tests++;
      if (w_out !== e[i]) begin failed++; $display("FAIL reset_mid_lw cyc %0d: got %b, expected %b", i, w_out, e[i]); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    mem_ready = 0;
    rst_n = 0; #1;
    tests++;
    if (w_out !== E_FETCH0) begin failed++; $display("FAIL reset_async: got %b, expected %b", w_out, E_FETCH0); end
    @(posedge clk); #1;
    mem_ready = 1; #1;
    tests++;
    if (w_out !== E_FETCH1 || reg_write !== 1'b0) begin failed++; $display("FAIL reset_held: got %b, expected %b", w_out, E_FETCH1); end
    @(posedge clk); #1;
    tests++;
    if (w_out !== E_FETCH1) begin failed++; $display("FAIL reset_hold_state: got %b, expected %b", w_out, E_FETCH1); end
    mem_ready = 0;
    rst_n = 1;
    @(posedge clk); #1;
    tests++;
    if (w_out !== E_FETCH0) begin failed++; $display("FAIL reset_release: got %b, expected %b", w_out, E_FETCH0); end
  endtask
  task automatic test_no_handshake();
    logic [16:0] e[$] = '{E_FETCH1, E_DEC, E_MEMADR, E_MEMWR, E_FETCH1};
    int mw = 0;
    mem_ready0 = 0;
    op0 = 6'h2B;
    rst0_n = 1; #1;
    foreach (e[i]) begin
      if (i < 4) mw += int'(mem_write0);
      tests++;
      if (w_out0 !== e[i]) begin failed++; $display("FAIL no_handshake cyc %0d: got %b, expected %b", i, w_out0, e[i]); end
      @(posedge clk); #2;
    end
    tests++;
    if (mw !== 1) begin failed++; $display("FAIL no_handshake_mem_write_cycles: got %0d, expected 1", mw); end
  endtask
  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi();
    test_jump();
    test_illegal();
    test_reset_mid_lw();
    test_no_handshake();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
